// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the multiplexed six-digit display scanner.
//   NUM_DIGITS / SEG_W / IDX_W : display geometry and digit-index width
//   seg_off()                  : "all segments dark" pattern for a polarity
//   an_off()                   : "no digit enabled" pattern for a polarity
//   an_on()                    : single-digit enable pattern for a polarity
//   clog2()                    : width helper for the dwell counter
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_W      = 7;
   localparam int IDX_W      = 3;

   // Smallest width w (at least 1) such that 2**w >= value, so value-1 fits.
   function automatic int clog2(input int value);
      int w;
      w = 32'sd1;
      while ((32'sd1 <<< w) < value) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

   function automatic logic [SEG_W-1:0] seg_off(input bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   function automatic logic [NUM_DIGITS-1:0] an_off(input bit active_low);
      return active_low ? 6'h3F : 6'h00;
   endfunction

   // Enable exactly one digit; an out-of-range index enables nothing.
   function automatic logic [NUM_DIGITS-1:0] an_on(input logic [IDX_W-1:0] idx,
                                                   input bit               active_low);
      logic [NUM_DIGITS-1:0] onehot;
      onehot = 6'b000001 << idx;
      return active_low ? ~onehot : onehot;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Dwell counter (0..DWELL-1) and digit index (0..NUM_DIGITS-1) for the scanner.
//   clk, rst_n    : clock, asynchronous active-low reset
//   idx           : digit currently being scanned
//   blank         : high during the first BLANK_CYCLES cycles of each dwell
//   frame_strobe  : high in the first cycle of digit 0 (frame boundary)
// The flags are decoded from the counter registers; the consumer registers them.
// -----------------------------------------------------------------------------
module scan_timer
   import display_pkg::*;
#(
   parameter int DWELL        = 50_000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [IDX_W-1:0] idx,
   output logic             blank,
   output logic             frame_strobe
);

   localparam int               CNT_W     = clog2(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [IDX_W-1:0] idx_r;

   // Dwell counter; the digit index steps on the last cycle of each dwell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         idx_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
         if (idx_r == IDX_LAST) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign idx          = idx_r;
   assign blank        = (cnt_r < CNT_BLANK);
   assign frame_strobe = (cnt_r == '0) && (idx_r == '0);

endmodule

// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
// Time-multiplexed scanner for a six-digit HH:MM:SS seven-segment module.
//   clk, rst_n   : clock, asynchronous active-low reset
//   seg_in       : six decoded digit patterns, digit i at [7i+6:7i]
//   blink_mask   : bit i set -> digit i blanks while the blink phase is 1
//   blink_tick   : one-cycle pulse toggling the blink phase
//   seg_out      : shared segment bus (registered)
//   an_out       : digit enables, at most one active (registered)
//   frame_start  : one-cycle pulse per frame snapshot (registered)
// The frame is captured only at the digit-0 boundary so a time update that
// lands mid-scan never shows half old / half new digits. Each dwell opens
// with a dark gap so the previous digit's segments cannot ghost onto the next.
// -----------------------------------------------------------------------------
module display_scan
   import display_pkg::*;
#(
   parameter int INPUT_HZ       = 50_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int BLANK_CYCLES   = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       blink_mask,
   input  logic                        blink_tick,
   output logic [SEG_W-1:0]            seg_out,
   output logic [NUM_DIGITS-1:0]       an_out,
   output logic                        frame_start
);

   localparam int                          DWELL     = INPUT_HZ / SCAN_HZ;
   localparam logic [SEG_W-1:0]            SEG_OFF   = seg_off(SEG_ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0]       AN_OFF    = an_off(AN_ACTIVE_LOW);
   localparam logic [NUM_DIGITS*SEG_W-1:0] FRAME_OFF = {NUM_DIGITS{SEG_OFF}};

   logic [IDX_W-1:0]            idx;
   logic                        blank;
   logic                        frame_strobe;
   logic [NUM_DIGITS*SEG_W-1:0] frame_r;
   logic                        blink_phase_r;
   logic [SEG_W-1:0]            digit_seg;
   logic [SEG_W-1:0]            seg_nxt;
   logic [NUM_DIGITS-1:0]       an_nxt;

   scan_timer #(
      .DWELL        (DWELL),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .idx          (idx),
      .blank        (blank),
      .frame_strobe (frame_strobe)
   );

   // Frame snapshot at the frame boundary; blink phase toggles on every tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_r       <= FRAME_OFF;
         blink_phase_r <= 1'b0;
      end else begin
         if (frame_strobe) begin
            frame_r <= seg_in;
         end
         if (blink_tick) begin
            blink_phase_r <= ~blink_phase_r;
         end
      end
   end

   // Pick the snapshot pattern of the digit being scanned.
   always_comb begin
      digit_seg = SEG_OFF;
      case (idx)
         3'd0:    digit_seg = frame_r[ 6: 0];
         3'd1:    digit_seg = frame_r[13: 7];
         3'd2:    digit_seg = frame_r[20:14];
         3'd3:    digit_seg = frame_r[27:21];
         3'd4:    digit_seg = frame_r[34:28];
         3'd5:    digit_seg = frame_r[41:35];
         default: digit_seg = SEG_OFF;
      endcase
   end

   // Next output values; blink darkens segments but keeps the anode driven so
   // the dwell timing (and brightness of the other digits) is unchanged.
   always_comb begin
      seg_nxt = SEG_OFF;
      an_nxt  = AN_OFF;
      if (blank) begin
         seg_nxt = SEG_OFF;
         an_nxt  = AN_OFF;
      end else begin
         an_nxt = an_on(idx, AN_ACTIVE_LOW);
         if (blink_phase_r && blink_mask[idx]) begin
            seg_nxt = SEG_OFF;
         end else begin
            seg_nxt = digit_seg;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out     <= SEG_OFF;
         an_out      <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         seg_out     <= seg_nxt;
         an_out      <= an_nxt;
         frame_start <= frame_strobe;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// -----------------------------------------------------------------------------
// tb_display_scan
// Directed bench for display_scan with DWELL=10, BLANK_CYCLES=2. Two instances
// share the stimulus: dut (both polarities active-low) and dut_h (both
// active-high). k counts clock edges since the last reset release; the state
// after edge k has dwell count k%10 and digit (k/10)%6, and the outputs after
// edge k+1 reflect that state.
// -----------------------------------------------------------------------------
module tb_display_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [41:0] seg_in;
   logic [5:0]  blink_mask;
   logic        blink_tick;
   logic [6:0]  seg_l, seg_h;
   logic [5:0]  an_l, an_h;
   logic        fs_l, fs_h;

   int          checks = 0;
   int          errors = 0;
   int          k;
   logic [41:0] st_frame_l, st_frame_h;
   logic        st_bp;
   logic [41:0] seg_a, seg_b;

   display_scan #(
      .INPUT_HZ(10), .SCAN_HZ(1), .BLANK_CYCLES(2),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .blink_mask(blink_mask),
      .blink_tick(blink_tick), .seg_out(seg_l), .an_out(an_l), .frame_start(fs_l)
   );

   display_scan #(
      .INPUT_HZ(10), .SCAN_HZ(1), .BLANK_CYCLES(2),
      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
   ) dut_h (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .blink_mask(blink_mask),
      .blink_tick(blink_tick), .seg_out(seg_h), .an_out(an_h), .frame_start(fs_h)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   // Expected segment bus for the state after edge kk.
   function automatic logic [6:0] exp_seg(input int kk, input logic [41:0] fr,
                                          input bit al, input logic bp,
                                          input logic [5:0] mask);
      int         c, d;
      logic [6:0] off;
      c   = kk % 10;
      d   = (kk / 10) % 6;
      off = al ? 7'h7F : 7'h00;
      if (c < 2)
         return off;
      else if (bp && mask[d])
         return off;
      else
         return fr[7*d +: 7];
   endfunction

   // Expected digit enables for the state after edge kk.
   function automatic logic [5:0] exp_an(input int kk, input bit al);
      int         c, d;
      logic [5:0] oh;
      c = kk % 10;
      d = (kk / 10) % 6;
      if (c < 2) oh = 6'h00;
      else       oh = 6'h01 << d;
      return al ? ~oh : oh;
   endfunction

   // One clock with full output comparison of both instances.
   task automatic tick();
      logic [6:0] es_l, es_h;
      logic [5:0] ea_l, ea_h;
      logic       efs;
      es_l = exp_seg(k, st_frame_l, 1'b1, st_bp, blink_mask);
      es_h = exp_seg(k, st_frame_h, 1'b0, st_bp, blink_mask);
      ea_l = exp_an(k, 1'b1);
      ea_h = exp_an(k, 1'b0);
      efs  = (k % 60 == 0);
      if (k % 60 == 0) begin
         st_frame_l = seg_in;
         st_frame_h = seg_in;
      end
      if (blink_tick) st_bp = ~st_bp;
      @(posedge clk);
      #1;
      k++;
      check("seg_l", 64'(seg_l), 64'(es_l));
      check("an_l",  64'(an_l),  64'(ea_l));
      check("fs_l",  64'(fs_l),  64'(efs));
      check("seg_h", 64'(seg_h), 64'(es_h));
      check("an_h",  64'(an_h),  64'(ea_h));
      check("fs_h",  64'(fs_h),  64'(efs));
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   task automatic raw_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      rst_n      = 1'b1;
      k          = 0;
      st_frame_l = {6{7'h7F}};
      st_frame_h = '0;
      st_bp      = 1'b0;
   endtask

   initial begin
      seg_a = '0;
      seg_b = '0;
      for (int i = 0; i < 6; i++) begin
         seg_a[7*i +: 7] = 7'h40 | 7'(i);
         seg_b[7*i +: 7] = 7'h20 | 7'(i);
      end
      rst_n      = 1'b0;
      seg_in     = seg_a;
      blink_mask = 6'h00;
      blink_tick = 1'b0;
      k          = 0;

      // Reset values, both polarities
      raw_tick(); raw_tick(); raw_tick();
      check("rst_seg_l", 64'(seg_l), 64'(7'h7F));
      check("rst_an_l",  64'(an_l),  64'(6'h3F));
      check("rst_fs_l",  64'(fs_l),  64'(1'b0));
      check("rst_seg_h", 64'(seg_h), 64'(7'h00));
      check("rst_an_h",  64'(an_h),  64'(6'h00));

      // Release: frame_start in 2nd cycle, digit 0 from 4th cycle for 8 cycles
      restart();
      run_to(1);
      check("first_fs",   64'(fs_l), 64'(1'b1));
      check("first_an",   64'(an_l), 64'(6'h3F));
      run_to(2);
      check("fs_drop",    64'(fs_l), 64'(1'b0));
      check("gap_an",     64'(an_l), 64'(6'h3F));
      run_to(3);
      check("d0_an_l",    64'(an_l),  64'(6'h3E));
      check("d0_seg_l",   64'(seg_l), 64'(7'h40));
      check("d0_an_h",    64'(an_h),  64'(6'h01));
      check("d0_seg_h",   64'(seg_h), 64'(7'h40));
      run_to(10);
      check("d0_last",    64'(an_l), 64'(6'h3E));
      run_to(11);
      check("d0_d1_gap",  64'(an_l), 64'(6'h3F));
      run_to(13);
      check("d1_an",      64'(an_l),  64'(6'h3D));
      check("d1_seg",     64'(seg_l), 64'(7'h41));
      run_to(61);
      check("fs_period",  64'(fs_l), 64'(1'b1));

      // Tearing: new seg_in while digit 2 is shown stays hidden this frame
      run_to(85);
      seg_in = seg_b;
      run_to(95);
      check("tear_old_d3", 64'(seg_l), 64'(7'h43));
      check("tear_an_d3",  64'(an_l),  64'(6'h37));
      run_to(121);
      check("fs_next",     64'(fs_l), 64'(1'b1));
      run_to(153);
      check("tear_new_d3", 64'(seg_l), 64'(7'h23));

      // Blink on digits 0 and 1
      run_to(175);
      blink_mask = 6'b000011;
      run_to(178);
      blink_tick = 1'b1;
      tick();
      blink_tick = 1'b0;
      run_to(185);
      check("blink_d0_seg", 64'(seg_l), 64'(7'h7F));
      check("blink_d0_an",  64'(an_l),  64'(6'h3E));
      check("blink_d0_h",   64'(seg_h), 64'(7'h00));
      check("blink_d0_anh", 64'(an_h),  64'(6'h01));
      run_to(195);
      check("blink_d1_seg", 64'(seg_l), 64'(7'h7F));
      check("blink_d1_an",  64'(an_l),  64'(6'h3D));
      run_to(205);
      check("blink_d2_seg", 64'(seg_l), 64'(7'h22));
      run_to(230);
      blink_tick = 1'b1;
      tick();
      blink_tick = 1'b0;
      run_to(245);
      check("unblink_d0",   64'(seg_l), 64'(7'h20));

      // Asynchronous reset during digit 4
      run_to(285);
      check("d4_an",       64'(an_l), 64'(6'h2F));
      rst_n = 1'b0;
      #1;
      check("async_an_l",  64'(an_l),  64'(6'h3F));
      check("async_seg_l", 64'(seg_l), 64'(7'h7F));
      check("async_an_h",  64'(an_h),  64'(6'h00));
      check("async_seg_h", 64'(seg_h), 64'(7'h00));
      check("async_fs",    64'(fs_l),  64'(1'b0));
      seg_in = seg_a;
      raw_tick(); raw_tick();
      check("hold_an_l",   64'(an_l), 64'(6'h3F));
      restart();
      run_to(1);
      check("re_fs",       64'(fs_l), 64'(1'b1));
      run_to(3);
      check("re_d0_an",    64'(an_l),  64'(6'h3E));
      check("re_d0_seg",   64'(seg_l), 64'(7'h40));
      run_to(62);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
